imm_decode_pipe: RTL

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

---
 rtl/imm_decode_pipe_pkg.sv | 40 ++++
 rtl/imm_decode_pipe_comb.sv | 95 +++++++++
 rtl/imm_decode_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/imm_decode_pipe_pkg.sv
// Shared instruction-format codes, RV opcode constants and buffer state
// encoding for the immediate decode pipeline.
package imm_decode_pipe_pkg;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // Sign-extend a 12-bit immediate field to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode_pipe_comb.sv
// Purely combinational instruction-format decode and immediate extraction.
// Immediates are first assembled as 32-bit signed values, then widened to XLEN.
module imm_decode_comb
  import imm_decode_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output fmt_e            fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      zimm_o,
  output logic            illegal_o,
  output logic            pcrel_o
);

  logic [6:0]  opc;
  logic [31:0] imm32;
  fmt_e        fmt;
  logic [4:0]  zimm;
  logic        bad;
  logic        pcrel;

  assign opc = instr_i[6:0];

  // Classify the opcode and assemble the format-specific immediate.
  always_comb begin
    fmt   = R_TYPE;
    imm32 = '0;
    zimm  = '0;
    bad   = 1'b0;
    pcrel = 1'b0;
    case (opc)
      OPC_OP: fmt = R_TYPE;
      OPC_OP_32: begin
        if (XLEN == 64) fmt = R_TYPE;
        else            bad = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        fmt   = I_TYPE;
        imm32 = sext12(instr_i[31:20]);
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt   = I_TYPE;
          imm32 = sext12(instr_i[31:20]);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        fmt   = I_TYPE;
        imm32 = sext12(instr_i[31:20]);
        if (instr_i[14]) zimm = instr_i[19:15];
      end
      OPC_STORE: begin
        fmt   = S_TYPE;
        imm32 = sext12({instr_i[31:25], instr_i[11:7]});
      end
      OPC_BRANCH: begin
        fmt   = B_TYPE;
        pcrel = 1'b1;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OPC_LUI: begin
        fmt   = U_TYPE;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        fmt   = U_TYPE;
        pcrel = 1'b1;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = J_TYPE;
        pcrel = 1'b1;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      default: bad = 1'b1;
    endcase
    // Compressed/non-32-bit encodings are rejected regardless of opcode match.
    if (instr_i[1:0] != 2'b11) bad = 1'b1;
  end

  // Illegal instructions present as an all-zero R-type entry.
  always_comb begin
    illegal_o = bad;
    fmt_o     = bad ? R_TYPE : fmt;
    imm_o     = bad ? '0 : XLEN'($signed(imm32));
    zimm_o    = bad ? '0 : zimm;
    pcrel_o   = bad ? 1'b0 : pcrel;
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decode pipeline: decode + branch/jump target adder feeding a
// two-entry (main + skid) output buffer with a registered in_ready.
module imm_decode_pipe
  import imm_decode_pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          TARGET_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_format,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_zimm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef struct packed {
    logic            illegal;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic [4:0]      zimm;
    logic [XLEN-1:0] target;
  } entry_t;

  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_zimm;
  logic            dec_illegal;
  logic            dec_pcrel;
  logic [XLEN-1:0] dec_target;
  entry_t          new_entry;

  occ_e   state_q, state_d;
  logic   in_ready_q;
  entry_t main_q, skid_q;
  logic   push, pop;
  logic   load_main_new, load_skid, main_from_skid;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i   (in_instr),
    .fmt_o     (dec_fmt),
    .imm_o     (dec_imm),
    .zimm_o    (dec_zimm),
    .illegal_o (dec_illegal),
    .pcrel_o   (dec_pcrel)
  );

  generate
    if (TARGET_EN) begin : g_target
      assign dec_target = dec_pcrel ? (in_pc + dec_imm) : '0;
    end else begin : g_no_target
      assign dec_target = '0;
    end
  endgenerate

  assign new_entry = '{illegal: dec_illegal, fmt: dec_fmt, imm: dec_imm,
                       zimm: dec_zimm, target: dec_target};

  assign push = in_valid && in_ready_q;
  assign pop  = out_ready && (state_q != ST_EMPTY);

  // Occupancy state and registered ready, derived from the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Next occupancy from push/pop handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_TWO;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_TWO:   if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output valid and buffer load controls decoded from occupancy.
  always_comb begin
    out_valid      = (state_q != ST_EMPTY);
    load_main_new  = push && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && pop));
    load_skid      = push && (state_q == ST_ONE) && !pop;
    main_from_skid = pop && (state_q == ST_TWO);
  end

  // Main entry drives the outputs; skid holds the younger entry when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new)       main_q <= new_entry;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= new_entry;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_format  = main_q.fmt;
  assign out_imm     = main_q.imm;
  assign out_zimm    = main_q.zimm;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;

endmodule
